time_counter_param: RTL and testbench

- Parametrised hours/minutes/seconds counter that replaces the fixed 24 h clock counter in the alarm-clock datapath.
- Sits between the 1 Hz tick generator and the display/alarm-compare logic.
- Adds generic moduli, adjustment with full borrow/carry cascade, a validated parallel load, a 12 h display mode, a day-wrap pulse, and deferral of ticks that collide with adjustments.

---
 rtl/time_counter_param.sv | 168 ++++++++++++++++
 tb/tb_time_counter_param.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter_param.sv
// Parametrised hh:mm:ss counter with adjust cascade, validated load, deferred ticks,
// day-wrap pulse and a 12 h display view.
module time_counter_param #(
  parameter int SEC_MOD     = 60,
  parameter int MIN_MOD     = 60,
  parameter int HOUR_MOD    = 24,
  parameter int RST_H       = 0,
  parameter int RST_M       = 0,
  parameter int RST_S       = 0,
  parameter int ADJ_CASCADE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       up_down,
  input  logic       adj_sec,
  input  logic       adj_min,
  input  logic       adj_hour,
  input  logic       mode_12h,
  input  logic       load_en,
  input  logic [6:0] load_h,
  input  logic [6:0] load_m,
  input  logic [6:0] load_s,
  output logic [6:0] sec_bin,
  output logic [6:0] min_bin,
  output logic [6:0] hour_bin,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_units,
  output logic       pm,
  output logic       day_tick,
  output logic       load_err,
  output logic       tick_pending
);

  localparam logic [6:0] SEC_M  = 7'(SEC_MOD);
  localparam logic [6:0] MIN_M  = 7'(MIN_MOD);
  localparam logic [6:0] HOUR_M = 7'(HOUR_MOD);
  localparam logic [6:0] RST_HV = 7'(RST_H);
  localparam logic [6:0] RST_MV = 7'(RST_M);
  localparam logic [6:0] RST_SV = 7'(RST_S);

  // Steps one field by +/-1 modulo m; bit 7 flags a wrap (carry or borrow).
  function automatic logic [7:0] step_field(input logic [6:0] v, input logic [6:0] m,
                                            input logic up);
    logic [7:0] r;
    if (up) begin
      if (v == m - 7'd1) r = {1'b1, 7'd0};
      else               r = {1'b0, v + 7'd1};
    end else begin
      if (v == 7'd0) r = {1'b1, m - 7'd1};
      else           r = {1'b0, v - 7'd1};
    end
    return r;
  endfunction

  logic [6:0] sec_r, min_r, hour_r;
  logic [6:0] sec_n, min_n, hour_n;
  logic       day_r, err_r, pend_r;
  logic       day_n, err_n, pend_n;
  logic [7:0] s_step, m_step, h_step;
  logic       eff_tick, any_adj, load_ok;
  logic [6:0] hour_disp;

  // Next-state: load beats adjust beats tick; a tick colliding with adjust is deferred.
  always_comb begin
    s_step   = step_field(sec_r, SEC_M, up_down);
    m_step   = step_field(min_r, MIN_M, up_down);
    h_step   = step_field(hour_r, HOUR_M, up_down);
    eff_tick = tick_1hz | pend_r;
    any_adj  = adj_sec | adj_min | adj_hour;
    load_ok  = (load_h < HOUR_M) && (load_m < MIN_M) && (load_s < SEC_M);
    sec_n    = sec_r;
    min_n    = min_r;
    hour_n   = hour_r;
    day_n    = 1'b0;
    err_n    = 1'b0;
    pend_n   = pend_r;
    if (load_en) begin
      if (load_ok) begin
        sec_n  = load_s;
        min_n  = load_m;
        hour_n = load_h;
        pend_n = 1'b0;
      end else begin
        err_n = 1'b1;
      end
    end else if (any_adj) begin
      pend_n = eff_tick;
      if (adj_sec) begin
        sec_n = s_step[6:0];
        if ((ADJ_CASCADE != 0) && s_step[7]) begin
          min_n = m_step[6:0];
          if (m_step[7]) hour_n = h_step[6:0];
          else           hour_n = hour_r;
        end else begin
          min_n = min_r;
        end
      end else if (adj_min) begin
        min_n = m_step[6:0];
        if ((ADJ_CASCADE != 0) && m_step[7]) hour_n = h_step[6:0];
        else                                 hour_n = hour_r;
      end else begin
        hour_n = h_step[6:0];
      end
    end else if (eff_tick) begin
      pend_n = 1'b0;
      sec_n  = s_step[6:0];
      if (s_step[7]) begin
        min_n = m_step[6:0];
        if (m_step[7]) begin
          hour_n = h_step[6:0];
          day_n  = h_step[7];
        end else begin
          hour_n = hour_r;
        end
      end else begin
        min_n = min_r;
      end
    end else begin
      pend_n = pend_r;
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_r  <= RST_SV;
      min_r  <= RST_MV;
      hour_r <= RST_HV;
      day_r  <= 1'b0;
      err_r  <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      sec_r  <= sec_n;
      min_r  <= min_n;
      hour_r <= hour_n;
      day_r  <= day_n;
      err_r  <= err_n;
      pend_r <= pend_n;
    end
  end

  // 12 h view remaps only the displayed hour.
  always_comb begin
    if (mode_12h && (hour_r == 7'd0))                         hour_disp = 7'd12;
    else if (mode_12h && (hour_r >= 7'd13) && (hour_r <= 7'd23)) hour_disp = hour_r - 7'd12;
    else                                                       hour_disp = hour_r;
  end

  assign sec_bin      = sec_r;
  assign min_bin      = min_r;
  assign hour_bin     = hour_r;
  assign sec_tens     = 4'(sec_r / 7'd10);
  assign sec_units    = 4'(sec_r % 7'd10);
  assign min_tens     = 4'(min_r / 7'd10);
  assign min_units    = 4'(min_r % 7'd10);
  assign hour_tens    = 4'(hour_disp / 7'd10);
  assign hour_units   = 4'(hour_disp % 7'd10);
  assign pm           = mode_12h & (hour_r >= 7'd12);
  assign day_tick     = day_r;
  assign load_err     = err_r;
  assign tick_pending = pend_r;

endmodule

// File: tb/tb_time_counter_param.sv
// Bench for time_counter_param: directed table, hand-written corner sequences, and
// random stimulus checked against a seconds-of-day reference model.
module tb_time_counter_param;

  logic       clk, rst, tick_1hz, up_down, adj_sec, adj_min, adj_hour, mode_12h, load_en;
  logic [6:0] load_h, load_m, load_s;
  logic [6:0] a_sec, a_min, a_hour, b_sec, b_min, b_hour;
  logic [3:0] a_st, a_su, a_mt, a_mu, a_ht, a_hu, b_st, b_su, b_mt, b_mu, b_ht, b_hu;
  logic       a_pm, a_day, a_err, a_pend, b_pm, b_day, b_err, b_pend;

  int total = 0;
  int bad   = 0;

  time_counter_param dut_a (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .up_down(up_down), .adj_sec(adj_sec),
    .adj_min(adj_min), .adj_hour(adj_hour), .mode_12h(mode_12h), .load_en(load_en),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .sec_bin(a_sec), .min_bin(a_min), .hour_bin(a_hour),
    .sec_tens(a_st), .sec_units(a_su), .min_tens(a_mt), .min_units(a_mu),
    .hour_tens(a_ht), .hour_units(a_hu), .pm(a_pm), .day_tick(a_day),
    .load_err(a_err), .tick_pending(a_pend));

  time_counter_param #(.ADJ_CASCADE(0)) dut_b (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .up_down(up_down), .adj_sec(adj_sec),
    .adj_min(adj_min), .adj_hour(adj_hour), .mode_12h(mode_12h), .load_en(load_en),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .sec_bin(b_sec), .min_bin(b_min), .hour_bin(b_hour),
    .sec_tens(b_st), .sec_units(b_su), .min_tens(b_mt), .min_units(b_mu),
    .hour_tens(b_ht), .hour_units(b_hu), .pm(b_pm), .day_tick(b_day),
    .load_err(b_err), .tick_pending(b_pend));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int ld, lh, lm, ls, tk, ud, asec, amin, ahr, m12;
    int eh, em, es, edt, ele, epd, epm, eht, ehu;
  } vec_t;

  vec_t vec[28];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int ld, input int lh, input int lm, input int ls, input int tk,
                       input int ud, input int asec, input int amin, input int ahr,
                       input int m12);
    load_en  = 1'(ld);
    load_h   = 7'(lh);
    load_m   = 7'(lm);
    load_s   = 7'(ls);
    tick_1hz = 1'(tk);
    up_down  = 1'(ud);
    adj_sec  = 1'(asec);
    adj_min  = 1'(amin);
    adj_hour = 1'(ahr);
    mode_12h = 1'(m12);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"}, 32'(a_hour), h);
    chk({tag, "_min"},  32'(a_min),  m);
    chk({tag, "_sec"},  32'(a_sec),  s);
  endtask

  initial begin
    int saw_day;
    int t, pend, day_len, ld, lh, lm, ls, tk, ud, asec, amin, ahr, m12;
    int ok, delta, edt, ele, h, m, s, hd;

    // reset state
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    repeat (3) cyc();
    chk_time("reset", 0, 0, 0);
    chk("reset_day", 32'(a_day), 0);
    chk("reset_err", 32'(a_err), 0);
    chk("reset_pend", 32'(a_pend), 0);
    @(negedge clk);
    rst = 1'b1;

    // 3725 consecutive up ticks from midnight
    saw_day = 0;
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3725; i++) begin
      cyc();
      if (a_day) saw_day = 1;
    end
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk_time("run3725", 1, 2, 5);
    chk("run3725_ht", 32'(a_ht), 0);
    chk("run3725_hu", 32'(a_hu), 1);
    chk("run3725_mt", 32'(a_mt), 0);
    chk("run3725_mu", 32'(a_mu), 2);
    chk("run3725_st", 32'(a_st), 0);
    chk("run3725_su", 32'(a_su), 5);
    chk("run3725_noday", 32'(saw_day), 0);

    // directed table: ld lh lm ls tk ud as am ah m12 | h m s dt le pd pm ht hu
    vec[0]  = '{1, 23, 59, 59, 0, 1, 0, 0, 0, 0,  23, 59, 59, 0, 0, 0, 0, 2, 3};
    vec[1]  = '{0,  0,  0,  0, 1, 1, 0, 0, 0, 0,   0,  0,  0, 1, 0, 0, 0, 0, 0};
    vec[2]  = '{0,  0,  0,  0, 0, 1, 0, 0, 0, 0,   0,  0,  0, 0, 0, 0, 0, 0, 0};
    vec[3]  = '{0,  0,  0,  0, 1, 0, 0, 0, 0, 0,  23, 59, 59, 1, 0, 0, 0, 2, 3};
    vec[4]  = '{0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  23, 59, 59, 0, 0, 0, 0, 2, 3};
    vec[5]  = '{1, 10, 59, 30, 0, 1, 0, 0, 0, 0,  10, 59, 30, 0, 0, 0, 0, 1, 0};
    vec[6]  = '{0,  0,  0,  0, 1, 1, 0, 1, 0, 0,  11,  0, 30, 0, 0, 1, 0, 1, 1};
    vec[7]  = '{0,  0,  0,  0, 0, 1, 0, 0, 0, 0,  11,  0, 31, 0, 0, 0, 0, 1, 1};
    vec[8]  = '{1, 24,  0,  0, 0, 1, 0, 0, 0, 0,  11,  0, 31, 0, 1, 0, 0, 1, 1};
    vec[9]  = '{0,  0,  0,  0, 0, 1, 0, 0, 0, 0,  11,  0, 31, 0, 0, 0, 0, 1, 1};
    vec[10] = '{1, 13,  5,  0, 0, 1, 0, 0, 0, 1,  13,  5,  0, 0, 0, 0, 1, 0, 1};
    vec[11] = '{0,  0,  0,  0, 0, 1, 0, 0, 0, 0,  13,  5,  0, 0, 0, 0, 0, 1, 3};
    vec[12] = '{1,  0,  0,  0, 0, 1, 0, 0, 0, 1,   0,  0,  0, 0, 0, 0, 0, 1, 2};
    vec[13] = '{1, 12,  0,  0, 0, 1, 0, 0, 0, 1,  12,  0,  0, 0, 0, 0, 1, 1, 2};
    vec[14] = '{0,  0,  0,  0, 0, 1, 1, 0, 1, 0,  12,  0,  1, 0, 0, 0, 0, 1, 2};
    vec[15] = '{1,  1,  2,  3, 1, 1, 0, 0, 0, 0,   1,  2,  3, 0, 0, 0, 0, 0, 1};
    vec[16] = '{0,  0,  0,  0, 1, 1, 0, 0, 1, 0,   2,  2,  3, 0, 0, 1, 0, 0, 2};
    vec[17] = '{0,  0,  0,  0, 1, 0, 1, 0, 0, 0,   2,  2,  2, 0, 0, 1, 0, 0, 2};
    vec[18] = '{0,  0,  0,  0, 0, 1, 0, 0, 0, 0,   2,  2,  3, 0, 0, 0, 0, 0, 2};
    vec[19] = '{1,  5, 60,  0, 0, 1, 0, 0, 0, 0,   2,  2,  3, 0, 1, 0, 0, 0, 2};
    vec[20] = '{0,  0,  0,  0, 0, 0, 0, 0, 1, 0,   1,  2,  3, 0, 0, 0, 0, 0, 1};
    vec[21] = '{1,  0,  0,  0, 0, 1, 0, 0, 0, 0,   0,  0,  0, 0, 0, 0, 0, 0, 0};
    vec[22] = '{0,  0,  0,  0, 0, 0, 1, 0, 0, 0,  23, 59, 59, 0, 0, 0, 0, 2, 3};
    vec[23] = '{0,  0,  0,  0, 0, 1, 0, 0, 0, 0,  23, 59, 59, 0, 0, 0, 0, 2, 3};
    vec[24] = '{0,  0,  0,  0, 1, 1, 1, 0, 0, 0,   0,  0,  0, 0, 0, 1, 0, 0, 0};
    vec[25] = '{1,  5,  0,  0, 0, 1, 0, 0, 0, 0,   5,  0,  0, 0, 0, 0, 0, 0, 5};
    vec[26] = '{0,  0,  0,  0, 0, 1, 0, 0, 0, 0,   5,  0,  0, 0, 0, 0, 0, 0, 5};
    vec[27] = '{0,  0,  0,  0, 0, 0, 1, 0, 0, 0,   4, 59, 59, 0, 0, 0, 0, 0, 4};

    for (int i = 0; i < 28; i++) begin
      drive(vec[i].ld, vec[i].lh, vec[i].lm, vec[i].ls, vec[i].tk, vec[i].ud,
            vec[i].asec, vec[i].amin, vec[i].ahr, vec[i].m12);
      cyc();
      chk($sformatf("vec%0d_hour", i), 32'(a_hour), vec[i].eh);
      chk($sformatf("vec%0d_min", i),  32'(a_min),  vec[i].em);
      chk($sformatf("vec%0d_sec", i),  32'(a_sec),  vec[i].es);
      chk($sformatf("vec%0d_day", i),  32'(a_day),  vec[i].edt);
      chk($sformatf("vec%0d_err", i),  32'(a_err),  vec[i].ele);
      chk($sformatf("vec%0d_pend", i), 32'(a_pend), vec[i].epd);
      chk($sformatf("vec%0d_pm", i),   32'(a_pm),   vec[i].epm);
      chk($sformatf("vec%0d_ht", i),   32'(a_ht),   vec[i].eht);
      chk($sformatf("vec%0d_hu", i),   32'(a_hu),   vec[i].ehu);
    end

    // non-cascading build: seconds borrow stays inside the seconds field
    chk("nocasc_hour", 32'(b_hour), 5);
    chk("nocasc_min",  32'(b_min),  0);
    chk("nocasc_sec",  32'(b_sec),  59);

    // asynchronous reset between edges with a tick pending
    drive(1, 7, 30, 14, 0, 1, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk_time("prearst", 7, 30, 15);
    chk("prearst_pend", 32'(a_pend), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_time("arst", 0, 0, 0);
    chk("arst_pend", 32'(a_pend), 0);
    chk("arst_day", 32'(a_day), 0);
    chk("arst_err", 32'(a_err), 0);
    #1;
    rst = 1'b1;
    cyc();
    chk_time("postarst_idle", 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    cyc();
    chk_time("postarst_tick", 0, 0, 1);

    // random phase: model keeps the time as seconds since midnight
    day_len = 24 * 60 * 60;
    t = 1;
    pend = 0;
    for (int n = 0; n < 600; n++) begin
      ld = ($urandom_range(0, 14) == 0) ? 1 : 0;
      if ($urandom_range(0, 1) == 1) begin
        lh = $urandom_range(0, 23); lm = $urandom_range(0, 59); ls = $urandom_range(0, 59);
      end else begin
        lh = $urandom_range(0, 127); lm = $urandom_range(0, 127); ls = $urandom_range(0, 127);
      end
      tk   = $urandom_range(0, 1);
      ud   = $urandom_range(0, 3) == 0 ? 0 : 1;
      asec = ($urandom_range(0, 9) == 0) ? 1 : 0;
      amin = ($urandom_range(0, 9) == 0) ? 1 : 0;
      ahr  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      m12  = $urandom_range(0, 1);
      drive(ld, lh, lm, ls, tk, ud, asec, amin, ahr, m12);

      edt = 0;
      ele = 0;
      ok = (lh < 24 && lm < 60 && ls < 60) ? 1 : 0;
      if (ld == 1) begin
        if (ok == 1) begin
          t = lh * 3600 + lm * 60 + ls;
          pend = 0;
        end else begin
          ele = 1;
        end
      end else if (asec + amin + ahr > 0) begin
        delta = (asec == 1) ? 1 : ((amin == 1) ? 60 : 3600);
        t = (ud == 1) ? (t + delta) % day_len : (t - delta + day_len) % day_len;
        pend = (tk == 1 || pend == 1) ? 1 : 0;
      end else if (tk == 1 || pend == 1) begin
        if (ud == 1) begin
          edt = (t == day_len - 1) ? 1 : 0;
          t = (t + 1) % day_len;
        end else begin
          edt = (t == 0) ? 1 : 0;
          t = (t + day_len - 1) % day_len;
        end
        pend = 0;
      end

      cyc();
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      hd = h;
      if (m12 == 1 && h == 0) hd = 12;
      else if (m12 == 1 && h > 12) hd = h - 12;
      chk("rnd_hour", 32'(a_hour), h);
      chk("rnd_min",  32'(a_min),  m);
      chk("rnd_sec",  32'(a_sec),  s);
      chk("rnd_day",  32'(a_day),  edt);
      chk("rnd_err",  32'(a_err),  ele);
      chk("rnd_pend", 32'(a_pend), pend);
      chk("rnd_pm",   32'(a_pm),   (m12 == 1 && h >= 12) ? 1 : 0);
      chk("rnd_ht",   32'(a_ht),   hd / 10);
      chk("rnd_hu",   32'(a_hu),   hd % 10);
      chk("rnd_mt",   32'(a_mt),   m / 10);
      chk("rnd_mu",   32'(a_mu),   m % 10);
      chk("rnd_st",   32'(a_st),   s / 10);
      chk("rnd_su",   32'(a_su),   s % 10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
